csel_addsub_pipe: RTL and testbench

- Parametrised, 2-stage pipelined carry-select adder/subtractor. Generalises the team's fixed 32-bit, two-half combinational carry-select adder.
- Adds configurable width and segment size, subtract and signed-saturation modes, status flags, a tag passthrough, and valid/ready flow control.
- Sits between operand-issue logic and the result writeback path as a streaming arithmetic unit.

---
 rtl/csel_addsub_pipe.sv | 163 ++++++++++++++++
 tb/tb_csel_addsub_pipe.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/csel_addsub_pipe.sv
// Two-stage pipelined carry-select adder/subtractor with signed saturation,
// status flags, tag passthrough and elastic valid/ready handshaking.
module csel_addsub_pipe #(
  parameter int WIDTH = 32,
  parameter int SEG   = 8,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [TAG_W-1:0] tag_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow,
  output logic             zero,
  output logic             negative,
  output logic [TAG_W-1:0] tag_out
);

  localparam int NSEG = WIDTH / SEG;

  function automatic logic signed [WIDTH-1:0] saturate(
    input logic signed [WIDTH-1:0] raw,
    input logic                    ovf,
    input logic                    sat_en,
    input logic                    a_msb
  );
    logic signed [WIDTH-1:0] max_pos;
    logic signed [WIDTH-1:0] min_neg;
    max_pos = {1'b0, {(WIDTH-1){1'b1}}};
    min_neg = {1'b1, {(WIDTH-1){1'b0}}};
    if (sat_en && ovf)
      return a_msb ? min_neg : max_pos;
    return raw;
  endfunction

  logic vld_p1;
  logic vld_p2;
  logic s1_adv;
  logic s2_adv;

  assign s2_adv   = !vld_p2 || out_ready;
  assign s1_adv   = !vld_p1 || s2_adv;
  assign in_ready = s1_adv;

  // Operand prep: subtraction is a + ~b + 1, so cin only matters for adds
  logic             is_sub;
  logic [WIDTH-1:0] b_eff;
  logic             c_eff;

  assign is_sub = op[0];
  assign b_eff  = is_sub ? ~b : b;
  assign c_eff  = is_sub ? 1'b1 : cin;

  logic [SEG:0] seg0_c;
  logic [SEG:0] lo_c [1:NSEG-1];
  logic [SEG:0] hi_c [1:NSEG-1];

  always_comb begin
    seg0_c = {1'b0, a[SEG-1:0]} + {1'b0, b_eff[SEG-1:0]} + {{SEG{1'b0}}, c_eff};
    for (int k = 1; k < NSEG; k++) begin
      lo_c[k] = {1'b0, a[k*SEG +: SEG]} + {1'b0, b_eff[k*SEG +: SEG]};
      hi_c[k] = {1'b0, a[k*SEG +: SEG]} + {1'b0, b_eff[k*SEG +: SEG]}
                + {{SEG{1'b0}}, 1'b1};
    end
  end

  // ---- stage 1: segment sums and both carry candidates ----
  logic [SEG:0]     seg0_p1;
  logic [SEG:0]     lo_p1 [1:NSEG-1];
  logic [SEG:0]     hi_p1 [1:NSEG-1];
  logic             sat_p1;
  logic             a_msb_p1;
  logic             b_msb_p1;
  logic [TAG_W-1:0] tag_p1;

  always_ff @(posedge clk) begin
    if (rst)
      vld_p1 <= 1'b0;
    else if (s1_adv)
      vld_p1 <= in_valid;
  end

  always_ff @(posedge clk) begin
    if (s1_adv && in_valid) begin
      seg0_p1  <= seg0_c;
      lo_p1    <= lo_c;
      hi_p1    <= hi_c;
      sat_p1   <= op[1];
      a_msb_p1 <= a[WIDTH-1];
      b_msb_p1 <= b_eff[WIDTH-1];
      tag_p1   <= tag_in;
    end
  end

  // Select chain: each segment's carry picks the next segment's candidate
  logic signed [WIDTH-1:0] raw_c;
  logic                    carry_c;
  logic                    cmsb_c;
  logic                    ovf_c;
  logic signed [WIDTH-1:0] res_c;

  always_comb begin
    raw_c            = '0;
    raw_c[SEG-1:0]   = seg0_p1[SEG-1:0];
    carry_c          = seg0_p1[SEG];
    for (int k = 1; k < NSEG; k++) begin
      raw_c[k*SEG +: SEG] = carry_c ? hi_p1[k][SEG-1:0] : lo_p1[k][SEG-1:0];
      carry_c             = carry_c ? hi_p1[k][SEG]     : lo_p1[k][SEG];
    end
  end

  // Carry into the MSB falls out of the sum bit and both operand MSBs
  assign cmsb_c = raw_c[WIDTH-1] ^ a_msb_p1 ^ b_msb_p1;
  assign ovf_c  = cmsb_c ^ carry_c;
  assign res_c  = saturate(raw_c, ovf_c, sat_p1, a_msb_p1);

  // ---- stage 2: selected result and flags ----
  logic signed [WIDTH-1:0] result_p2;
  logic                    cout_p2;
  logic                    ovf_p2;
  logic                    zero_p2;
  logic                    neg_p2;
  logic [TAG_W-1:0]        tag_p2;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p2    <= 1'b0;
      result_p2 <= '0;
      cout_p2   <= 1'b0;
      ovf_p2    <= 1'b0;
      zero_p2   <= 1'b0;
      neg_p2    <= 1'b0;
      tag_p2    <= '0;
    end else if (s2_adv) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        result_p2 <= res_c;
        cout_p2   <= carry_c;
        ovf_p2    <= ovf_c;
        zero_p2   <= (res_c == '0);
        neg_p2    <= res_c[WIDTH-1];
        tag_p2    <= tag_p1;
      end
    end
  end

  assign out_valid = vld_p2;
  assign result    = result_p2;
  assign cout      = cout_p2;
  assign overflow  = ovf_p2;
  assign zero      = zero_p2;
  assign negative  = neg_p2;
  assign tag_out   = tag_p2;

endmodule

// File: tb/tb_csel_addsub_pipe.sv
// Scoreboard bench for csel_addsub_pipe: directed arithmetic corners,
// latency, backpressure, mid-op reset, and a randomised stream.
module tb_csel_addsub_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        cin;
  logic [3:0]  tag_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        cout;
  logic        overflow;
  logic        zero;
  logic        negative;
  logic [3:0]  tag_out;

  always #5 clk = ~clk;

  csel_addsub_pipe #(.WIDTH(32), .SEG(8), .TAG_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .cin(cin), .tag_in(tag_in),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .cout(cout), .overflow(overflow), .zero(zero), .negative(negative),
    .tag_out(tag_out)
  );

  typedef struct packed {
    logic [31:0] result;
    logic        cout;
    logic        ovf;
    logic        zero;
    logic        neg;
    logic [3:0]  tag;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   popped = 0;
  bit   rand_ready = 1'b0;

  task automatic check(input string nm, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", nm, obs, exp);
    end
  endtask

  // Reference: one wide add, saturation from operand signs
  function automatic exp_t model(input logic [1:0] opv, input logic [31:0] av,
                                 input logic [31:0] bv, input logic cv,
                                 input logic [3:0] tv);
    logic [32:0] s;
    logic [31:0] be;
    logic        c;
    exp_t        e;
    be       = opv[0] ? ~bv : bv;
    c        = opv[0] ? 1'b1 : cv;
    s        = {1'b0, av} + {1'b0, be} + {32'b0, c};
    e.cout   = s[32];
    e.ovf    = (av[31] == be[31]) && (s[31] != av[31]);
    e.result = (opv[1] && e.ovf) ? (av[31] ? 32'h8000_0000 : 32'h7FFF_FFFF) : s[31:0];
    e.zero   = (e.result == 32'h0);
    e.neg    = e.result[31];
    e.tag    = tv;
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (q.size() == 0) begin
        check("unexpected_output", {60'h0, tag_out}, 64'hDEAD);
      end else begin
        check("result",   {32'h0, result},   {32'h0, q[0].result});
        check("cout",     {63'h0, cout},     {63'h0, q[0].cout});
        check("overflow", {63'h0, overflow}, {63'h0, q[0].ovf});
        check("zero",     {63'h0, zero},     {63'h0, q[0].zero});
        check("negative", {63'h0, negative}, {63'h0, q[0].neg});
        check("tag",      {60'h0, tag_out},  {60'h0, q[0].tag});
        if (out_ready) begin
          void'(q.pop_front());
          popped++;
        end
      end
    end
  end

  always @(posedge clk) begin
    if (rand_ready) begin
      #1;
      out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Entered and left at 1 time unit after a rising edge
  task automatic send(input logic [1:0] opv, input logic [31:0] av,
                      input logic [31:0] bv, input logic cv, input logic [3:0] tv);
    int n;
    n        = 0;
    in_valid = 1'b1;
    op       = opv;
    a        = av;
    b        = bv;
    cin      = cv;
    tag_in   = tv;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("accept_timeout", 64'h0, 64'h1);
    else q.push_back(model(opv, av, bv, cv, tv));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic lat_op(input logic [1:0] opv, input logic [31:0] av,
                        input logic [31:0] bv, input logic cv, input logic [3:0] tv);
    send(opv, av, bv, cv, tv);
    @(negedge clk);
    check("latency_cycle1", {63'h0, out_valid}, 64'h0);
    @(negedge clk);
    check("latency_cycle2", {63'h0, out_valid}, 64'h1);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int nxt;
    int base;
    int n;
    rst       = 1'b1;
    in_valid  = 1'b1;
    op        = 2'b00;
    a         = 32'h1234;
    b         = 32'h1;
    cin       = 1'b0;
    tag_in    = 4'hF;
    out_ready = 1'b1;

    // Reset held two cycles with an op offered
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_out_valid", {63'h0, out_valid}, 64'h0);
    check("rst_result",    {32'h0, result},    64'h0);
    @(posedge clk); #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("rst_in_ready", {63'h0, in_ready},  64'h1);
    check("rst_tag_out",  {60'h0, tag_out},   64'h0);
    check("rst_zero",     {63'h0, zero},      64'h0);
    check("rst_cout",     {63'h0, cout},      64'h0);
    repeat (3) begin
      @(negedge clk);
      check("rst_no_capture", {63'h0, out_valid}, 64'h0);
    end
    @(posedge clk); #1;

    // Directed arithmetic corners
    lat_op(2'b00, 32'h00FF_FFFF, 32'h0000_0001, 1'b0, 4'd1);
    lat_op(2'b00, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 4'd2);
    lat_op(2'b00, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 4'd3);
    lat_op(2'b10, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 4'd4);
    lat_op(2'b11, 32'h8000_0000, 32'h0000_0001, 1'b0, 4'd5);
    lat_op(2'b01, 32'h0000_0005, 32'h0000_0005, 1'b1, 4'd6);
    lat_op(2'b01, 32'h0000_0003, 32'h0000_0005, 1'b1, 4'd7);
    lat_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 4'd8);
    check("directed_drained", q.size(), 64'h0);

    // Backpressure: tags 1..5 back to back, consumer stalls cycles 3-6
    nxt  = 1;
    base = popped;
    for (int c = 1; c <= 12; c++) begin
      out_ready = !(c >= 3 && c <= 6);
      in_valid  = (nxt <= 5);
      op        = 2'(nxt % 4);
      a         = 32'h0101_0101 * nxt;
      b         = 32'h00FF_00FF + nxt;
      cin       = nxt[0];
      tag_in    = 4'(nxt);
      @(negedge clk);
      if (c >= 3 && c <= 6) check("bp_in_ready_low", {63'h0, in_ready}, 64'h0);
      if (c >= 3 && c <= 11) check("bp_no_gap", {63'h0, out_valid}, 64'h1);
      if (c == 12) check("bp_no_dup", {63'h0, out_valid}, 64'h0);
      if (in_valid && in_ready) begin
        q.push_back(model(op, a, b, cin, tag_in));
        nxt++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("bp_count", popped - base, 64'd5);
    check("bp_drained", q.size(), 64'h0);

    // Mid-op reset discards two in-flight ops
    out_ready = 1'b0;
    send(2'b00, 32'h1111_1111, 32'h2222_2222, 1'b0, 4'hA);
    send(2'b01, 32'h3333_3333, 32'h1111_1111, 1'b0, 4'hB);
    rst = 1'b1;
    @(posedge clk); #1;
    rst       = 1'b0;
    q.delete();
    out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("midrst_out_valid", {63'h0, out_valid}, 64'h0);
    end
    @(posedge clk); #1;
    lat_op(2'b00, 32'h0000_0010, 32'h0000_0020, 1'b1, 4'hC);

    // Random stream under random consumer backpressure
    rand_ready = 1'b1;
    for (int i = 0; i < 40; i++)
      send(2'($urandom_range(0, 3)), pick(), pick(), 1'($urandom_range(0, 1)),
           4'($urandom_range(0, 15)));
    rand_ready = 1'b0;
    @(posedge clk); #2;
    out_ready = 1'b1;
    n = 0;
    while (q.size() != 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    #2;
    check("random_drained", q.size(), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
